// File: rtl/wb_bus_arbiter_if.sv
// Wishbone B4 classic link bundle: one instance per master port and one for the shared slave bus.
interface wb_bus_arbiter_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              cyc;
   logic              stb;
   logic              we;
   logic [3:0]        sel;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       dat_w;
   logic [31:0]       dat_r;
   logic              ack;
   logic              err;

   modport master (
      output cyc, stb, we, sel, addr, dat_w,
      input  dat_r, ack, err
   );

   modport slave (
      input  cyc, stb, we, sel, addr, dat_w,
      output dat_r, ack, err
   );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter (m0 = fetch, m1 = data) with a stalled-transfer watchdog.
// Define WB_ARB_ROUND_ROBIN_EN to break simultaneous requests by last owner instead of data priority.
module wb_bus_arbiter #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   wb_bus_arbiter_if.slave  m0,
   wb_bus_arbiter_if.slave  m1,
   wb_bus_arbiter_if.master wbs,
   output logic [1:0]       grant_o,
   output logic             timeout_o
);

   typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

   localparam logic [7:0] WdogLast = 8'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [7:0]        wdog_q, wdog_d;
   logic              gnt0, gnt1;
   logic              own_cyc, own_stb, own_we;
   logic [3:0]        own_sel;
   logic [ADDR_W-1:0] own_addr;
   logic [31:0]       own_dat;
   logic              fire;
   state_e            both_pick;

`ifdef WB_ARB_ROUND_ROBIN_EN
   logic last_q, last_d;

   assign both_pick = last_q ? StGnt0 : StGnt1;

   always_comb begin
      last_d = last_q;
      if (state_q == StIdle && state_d == StGnt1) begin
         last_d = 1'b1;
      end else if (state_q == StIdle && state_d == StGnt0) begin
         last_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= 1'b0;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign both_pick = StGnt1;
`endif

   assign gnt0 = (state_q == StGnt0);
   assign gnt1 = (state_q == StGnt1);

   always_comb begin
      own_cyc  = 1'b0;
      own_stb  = 1'b0;
      own_we   = 1'b0;
      own_sel  = '0;
      own_addr = '0;
      own_dat  = '0;
      if (gnt1) begin
         own_cyc  = m1.cyc;
         own_stb  = m1.stb;
         own_we   = m1.we;
         own_sel  = m1.sel;
         own_addr = m1.addr;
         own_dat  = m1.dat_w;
      end else if (gnt0) begin
         own_cyc  = m0.cyc;
         own_stb  = m0.stb;
         own_we   = m0.we;
         own_sel  = m0.sel;
         own_addr = m0.addr;
         own_dat  = m0.dat_w;
      end
   end

   always_comb begin
      state_d = state_q;
      wdog_d  = wdog_q;
      fire    = 1'b0;
      unique case (state_q)
         StIdle: begin
            wdog_d = '0;
            if (m0.cyc && m1.cyc) begin
               state_d = both_pick;
            end else if (m1.cyc) begin
               state_d = StGnt1;
            end else if (m0.cyc) begin
               state_d = StGnt0;
            end
         end
         StGnt0, StGnt1: begin
            if (wbs.ack || wbs.err) begin
               wdog_d = '0;
            end else if (own_stb) begin
               if (wdog_q == WdogLast) begin
                  fire   = 1'b1;
                  wdog_d = '0;
               end else begin
                  wdog_d = wdog_q + 8'd1;
               end
            end
            // Releasing to idle (not straight to the other master) guarantees a gap cycle.
            if (fire || !own_cyc) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            wdog_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         wdog_q  <= wdog_d;
      end
   end

   // A watchdog abort withdraws the request from the slave in the same cycle it errs the master.
   assign wbs.cyc   = own_cyc & ~fire;
   assign wbs.stb   = own_stb & ~fire;
   assign wbs.we    = own_we;
   assign wbs.sel   = own_sel;
   assign wbs.addr  = own_addr;
   assign wbs.dat_w = own_dat;

   assign m0.ack   = gnt0 & wbs.ack;
   assign m0.err   = gnt0 & (wbs.err | fire);
   assign m0.dat_r = gnt0 ? wbs.dat_r : 32'd0;
   assign m1.ack   = gnt1 & wbs.ack;
   assign m1.err   = gnt1 & (wbs.err | fire);
   assign m1.dat_r = gnt1 ? wbs.dat_r : 32'd0;

   assign grant_o   = {gnt1, gnt0};
   assign timeout_o = fire;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Table-driven bench for wb_bus_arbiter (default fixed-priority build) with an expectation queue.
module tb_wb_bus_arbiter;
   localparam int unsigned TIMEOUT = 16;
   localparam logic [31:0] M0_ADDR = 32'h0000_0100;
   localparam logic [31:0] M1_ADDR = 32'h8000_0000;
   localparam logic [3:0]  M0_SEL  = 4'hF;
   localparam logic [3:0]  M1_SEL  = 4'b0011;
   localparam logic [31:0] M0_WD   = 32'hC0DE_0000;
   localparam logic [31:0] M1_WD   = 32'hDEAD_BEEF;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic [1:0] grant;
   logic       timeout;

   always #5 clk = ~clk;

   wb_bus_arbiter_if #(.ADDR_W(32)) m0_if ();
   wb_bus_arbiter_if #(.ADDR_W(32)) m1_if ();
   wb_bus_arbiter_if #(.ADDR_W(32)) wbs_if ();

   wb_bus_arbiter #(
      .TIMEOUT(TIMEOUT),
      .ADDR_W (32)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_ni),
      .m0       (m0_if),
      .m1       (m1_if),
      .wbs      (wbs_if),
      .grant_o  (grant),
      .timeout_o(timeout)
   );

   typedef struct {
      string       name;
      logic        m0c, m0s, m1c, m1s, ack, err;
      logic [31:0] rd;
      logic [1:0]  gnt;
      logic        m0a, m0e, m1a, m1e, to;
   } vec_t;

   vec_t         tbl[$];
   logic [141:0] exp_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;

   // in = {m0_cyc, m0_stb, m1_cyc, m1_stb, ack, err}; o = {m0_ack, m0_err, m1_ack, m1_err, timeout}
   function automatic vec_t mk(string name, logic [5:0] in, logic [31:0] rd, logic [1:0] gnt,
                               logic [4:0] o);
      vec_t v;
      v.name = name;
      {v.m0c, v.m0s, v.m1c, v.m1s, v.ack, v.err} = in;
      v.rd  = rd;
      v.gnt = gnt;
      {v.m0a, v.m0e, v.m1a, v.m1e, v.to} = o;
      return v;
   endfunction

   function automatic logic [141:0] expect_of(vec_t v);
      logic        cyc, stb, we;
      logic [3:0]  sel;
      logic [31:0] addr, wd, d0, d1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; addr = '0; wd = '0; d0 = '0; d1 = '0;
      if (v.gnt == 2'b01) begin
         cyc = v.m0c & ~v.to; stb = v.m0s & ~v.to; we = 1'b0;
         sel = M0_SEL; addr = M0_ADDR; wd = M0_WD; d0 = v.rd;
      end else if (v.gnt == 2'b10) begin
         cyc = v.m1c & ~v.to; stb = v.m1s & ~v.to; we = 1'b1;
         sel = M1_SEL; addr = M1_ADDR; wd = M1_WD; d1 = v.rd;
      end
      return {v.gnt, v.m0a, v.m0e, v.m1a, v.m1e, v.to, cyc, stb, we, sel, addr, wd, d0, d1};
   endfunction

   function automatic logic [141:0] observe();
      return {grant, m0_if.ack, m0_if.err, m1_if.ack, m1_if.err, timeout, wbs_if.cyc, wbs_if.stb,
              wbs_if.we, wbs_if.sel, wbs_if.addr, wbs_if.dat_w, m0_if.dat_r, m1_if.dat_r};
   endfunction

   task automatic check(string name, logic [141:0] got, logic [141:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic drive(vec_t v);
      m0_if.cyc    = v.m0c;
      m0_if.stb    = v.m0s;
      m1_if.cyc    = v.m1c;
      m1_if.stb    = v.m1s;
      wbs_if.ack   = v.ack;
      wbs_if.err   = v.err;
      wbs_if.dat_r = v.rd;
      exp_q.push_back(expect_of(v));
   endtask

   task automatic apply(vec_t v);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got empty queue want entry", v.name);
      end else begin
         check(v.name, observe(), exp_q.pop_front());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "time limit");
   end

   initial begin
      m0_if.we = 1'b0; m0_if.sel = M0_SEL; m0_if.addr = M0_ADDR; m0_if.dat_w = M0_WD;
      m1_if.we = 1'b1; m1_if.sel = M1_SEL; m1_if.addr = M1_ADDR; m1_if.dat_w = M1_WD;
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
      wbs_if.ack = 1'b0; wbs_if.err = 1'b0; wbs_if.dat_r = '0;

      // Reset held while the fetch master requests; first row after release expects the grant.
      for (int i = 0; i < 3; i++) tbl.push_back(mk("reset", 6'b110000, 32'h0, 2'b00, 5'b00000));
      tbl.push_back(mk("m0_gnt",   6'b110000, 32'h0,         2'b01, 5'b00000));
      tbl.push_back(mk("m0_wait",  6'b110000, 32'h0,         2'b01, 5'b00000));
      tbl.push_back(mk("m0_ack",   6'b110010, 32'h13,        2'b01, 5'b10000));
      tbl.push_back(mk("m0_drop",  6'b000000, 32'h0,         2'b01, 5'b00000));
      tbl.push_back(mk("idle",     6'b000000, 32'h0,         2'b00, 5'b00000));
      tbl.push_back(mk("both_req", 6'b111100, 32'h0,         2'b00, 5'b00000));
      tbl.push_back(mk("m1_win",   6'b111110, 32'hAAAA_5555, 2'b10, 5'b00100));
      tbl.push_back(mk("m1_drop",  6'b110000, 32'h0,         2'b10, 5'b00000));
      tbl.push_back(mk("gap",      6'b110000, 32'h0,         2'b00, 5'b00000));
      tbl.push_back(mk("m0_late",  6'b110010, 32'h1234_5678, 2'b01, 5'b10000));
      tbl.push_back(mk("m0_rel",   6'b000000, 32'h0,         2'b01, 5'b00000));
      tbl.push_back(mk("idle2",    6'b000000, 32'h0,         2'b00, 5'b00000));
      tbl.push_back(mk("to_req",   6'b001100, 32'h0,         2'b00, 5'b00000));
      for (int i = 0; i < int'(TIMEOUT) - 1; i++)
         tbl.push_back(mk("to_wait", 6'b001100, 32'h0, 2'b10, 5'b00000));
      tbl.push_back(mk("to_fire",  6'b001100, 32'h0,         2'b10, 5'b00011));
      tbl.push_back(mk("to_idle",  6'b000000, 32'h0,         2'b00, 5'b00000));
      tbl.push_back(mk("bu_req",   6'b111100, 32'h0,         2'b00, 5'b00000));
      tbl.push_back(mk("bu_ack1",  6'b111110, 32'h11,        2'b10, 5'b00100));
      tbl.push_back(mk("bu_nostb", 6'b111000, 32'h0,         2'b10, 5'b00000));
      tbl.push_back(mk("bu_ack2",  6'b111110, 32'h22,        2'b10, 5'b00100));
      tbl.push_back(mk("bu_ackerr",6'b111111, 32'h33,        2'b10, 5'b00110));
      tbl.push_back(mk("bu_drop",  6'b110000, 32'h0,         2'b10, 5'b00000));
      tbl.push_back(mk("bu_gap",   6'b110000, 32'h0,         2'b00, 5'b00000));
      tbl.push_back(mk("bu_m0",    6'b110010, 32'h44,        2'b01, 5'b10000));
      tbl.push_back(mk("bu_m0rel", 6'b000000, 32'h0,         2'b01, 5'b00000));
      tbl.push_back(mk("bu_idle",  6'b000000, 32'h0,         2'b00, 5'b00000));
      tbl.push_back(mk("mr_req",   6'b110000, 32'h0,         2'b00, 5'b00000));
      tbl.push_back(mk("mr_gnt",   6'b110000, 32'h0,         2'b01, 5'b00000));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
         if (i == 2) rst_ni = 1'b1;
      end

      // Reset mid-transfer while the slave acks: everything clears at once, no termination leaks.
      @(posedge clk);
      #1;
      drive(mk("mr_reset", 6'b110010, 32'h55, 2'b00, 5'b00000));
      #2;
      rst_ni = 1'b0;
      #1;
      check("mr_reset", observe(), exp_q.pop_front());
      @(negedge clk);
      apply(mk("mr_hold", 6'b110000, 32'h0, 2'b00, 5'b00000));
      rst_ni = 1'b1;
      apply(mk("mr_rearb", 6'b110000, 32'h0, 2'b01, 5'b00000));
      apply(mk("mr_rel",   6'b000000, 32'h0, 2'b01, 5'b00000));
      apply(mk("mr_idle",  6'b000000, 32'h0, 2'b00, 5'b00000));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
Two-master Wishbone B4 classic arbiter in front of the single shared memory bus. Master 0 is the instruction-fetch port and master 1 is the data (load/store) port. It grants the bus to one master per cycle-window, routes the granted master's request to the slave and returns ack/err/data only to that master. A watchdog terminates transfers the slave never answers.

Parameters:
TIMEOUT, 16, cycles a granted strobe may wait for ack/err before the arbiter forces err (2..255)
ADDR_W, 32, address width

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous reset, active-low
m0_cyc_i / m0_stb_i / m0_we_i  in  1 each  fetch master controls
m0_sel_i  in  4  fetch byte select
m0_addr_i  in  ADDR_W  fetch address
m0_dat_i  in  32  fetch write data
m0_dat_o  out  32  read data to fetch
m0_ack_o / m0_err_o  out  1 each  termination to fetch
m1_cyc_i / m1_stb_i / m1_we_i  in  1 each  data master controls
m1_sel_i  in  4  data byte select
m1_addr_i  in  ADDR_W  data address
m1_dat_i  in  32  data write data
m1_dat_o  out  32  read data to data master
m1_ack_o / m1_err_o  out  1 each  termination to data master
wbs_cyc_o / wbs_stb_o / wbs_we_o  out  1 each  shared bus controls
wbs_sel_o  out  4  shared byte select
wbs_addr_o  out  ADDR_W  shared address
wbs_dat_o  out  32  shared write data
wbs_dat_i  in  32  slave read data
wbs_ack_i / wbs_err_i  in  1 each  slave termination
grant_o  out  2  one-hot current owner (bit0 = fetch, bit1 = data); 00 when idle
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- States: IDLE, GNT0, GNT1, registered. Async reset sends the FSM to IDLE and clears the watchdog counter.
- Reset values: grant_o = 0, timeout_o = 0. All wbs_* outputs are 0. All m*_ack_o and m*_err_o are 0. m*_dat_o are 0 while not granted.
- IDLE:
  - If only m0_cyc_i, go to GNT0. If only m1_cyc_i, go to GNT1.
  - If both, go to GNT1 (data priority, fixed).
  - The bus is not driven in IDLE. Grant latency is 1 cycle from cyc assertion.
- GNTx:
  - wbs_* = mx_* combinationally.
  - mx_ack_o = wbs_ack_i, mx_err_o = wbs_err_i, mx_dat_o = wbs_dat_i.
  - The non-granted master sees ack = err = 0 and dat = 0.
- Grant is held while mx_cyc_i = 1; back-to-back strobes under one cyc keep ownership. When mx_cyc_i = 0, return to IDLE next cycle. No re-grant occurs in that same cycle, so there is at least one idle cycle between owners.
- Watchdog: 8-bit counter.
  - Cleared in IDLE and on any wbs_ack_i or wbs_err_i.
  - Increments each cycle in GNTx with mx_stb_i = 1 and no termination.
  - When the count reaches TIMEOUT-1: mx_err_o = 1 for that one cycle, timeout_o = 1, wbs_cyc_o/wbs_stb_o forced 0 that cycle, FSM goes to IDLE.
- Slave ack and err asserted together: both pass through; the master treats it as err.
- A master dropping cyc mid-transfer (e.g. branch flush) releases the bus normally. The arbiter does not generate a termination for it.
- Reset asserted mid-transfer: outputs clear immediately (asynchronous), no termination is issued, and requests are re-arbitrated after reset release.

Optional Feature:
WB_ARB_ROUND_ROBIN_EN:
- Defined: a 1-bit last-owner register (reset 0 = fetch). On a simultaneous request in IDLE, grant goes to the master that did not own last. Single requests behave as above.
- Undefined: fixed data-port priority; no last-owner register.

Test Plan:
- Reset with rst_ni = 0 for 3 cycles while m0_cyc_i = 1 -> all outputs 0. Cycle 1 after release: grant_o = 01.
- m0 read, addr 0x0000_0100, slave acks 2 cycles after grant with dat 0x0000_0013 -> m0_ack_o = 1, m0_dat_o = 0x13, m1_ack_o = 0. After m0_cyc_i drops: grant_o = 00 the next cycle.
- m0 and m1 request in the same cycle -> grant_o = 10 (fixed). With WB_ARB_ROUND_ROBIN_EN and last owner = data -> grant_o = 01. Loser is granted after one idle cycle.
- m1 write, addr 0x8000_0000, sel 4'b0011, slave never acks, TIMEOUT = 16 -> 15 cycles after grant: m1_err_o = 1 and timeout_o = 1 for one cycle, grant_o = 00 the next cycle.
- m1 holds cyc across 3 strobes with 3 acks while m0 requests -> m0 stays ungranted, m0_ack_o stays 0 throughout. Grant passes to m0 after m1_cyc_i falls plus one idle cycle.
- Reset asserted while in GNT0 with stb pending -> wbs_cyc_o = 0 and grant_o = 00 in the same cycle, no ack/err to m0.
